// File: rtl/fir_coeff_sequencer.sv
// Front-end for the FIR core: steers the shared byte stream into coefficient writes or samples,
// flushes the delay line after every complete coefficient load and realigns the FIR result with a valid flag.
module fir_coeff_sequencer #(
    parameter int NUM_TAPS    = 4,
    parameter int DATA_W      = 8,
    parameter int OUT_W       = 11,
    parameter int FIR_LATENCY = 2
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_set_coeffs,
    input  logic                        i_in_valid,
    input  logic [DATA_W-1:0]           i_in_data,
    output logic                        o_in_ready,
    output logic                        o_coeff_we,
    output logic [$clog2(NUM_TAPS)-1:0] o_coeff_addr,
    output logic [DATA_W-1:0]           o_coeff_data,
    output logic                        o_fir_valid,
    output logic [DATA_W-1:0]           o_fir_data,
    input  logic [OUT_W-1:0]            i_fir_result,
    output logic                        o_out_valid,
    output logic [OUT_W-1:0]            o_out_data,
    output logic                        o_coeffs_ready,
    output logic                        o_busy,
    output logic                        o_err,
    input  logic                        i_err_clr
);

    localparam int CNT_W  = $clog2(NUM_TAPS + 1);
    localparam int ADDR_W = $clog2(NUM_TAPS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TAPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN} state_t;

    state_t r_state;
    state_t w_next_state;

    logic [CNT_W-1:0]       r_tap_cnt;
    logic [CNT_W-1:0]       r_flush_cnt;
    logic                   r_coeff_we;
    logic [ADDR_W-1:0]      r_coeff_addr;
    logic [DATA_W-1:0]      r_coeff_data;
    logic                   r_fir_valid;
    logic                   r_fir_flush;
    logic [DATA_W-1:0]      r_fir_data;
    logic [FIR_LATENCY-1:0] r_pipe_valid;
    logic [FIR_LATENCY-1:0] r_pipe_flush;
    logic                   r_out_valid;
    logic [OUT_W-1:0]       r_out_data;
    logic                   r_coeffs_ready;
    logic                   r_err;

    logic             w_accept;
    logic             w_coeff_wr;
    logic             w_last_tap;
    logic             w_drop;
    logic             w_abort;
    logic             w_flush_done;
    logic             w_sample;
    logic             w_enter_load;
    logic             w_real_tap;
    logic [CNT_W-1:0] w_tap_idx;

    // A byte seen in IDLE with set_coeffs high is already coefficient 0.
    assign w_accept     = i_in_valid & o_in_ready;
    assign w_coeff_wr   = w_accept & i_set_coeffs & ((r_state == S_IDLE) | (r_state == S_LOAD));
    assign w_tap_idx    = (r_state == S_LOAD) ? r_tap_cnt : '0;
    assign w_last_tap   = (r_state == S_LOAD) & w_coeff_wr & (r_tap_cnt == LAST_IDX);
    assign w_drop       = (r_state == S_IDLE) & w_accept & ~i_set_coeffs;
    assign w_abort      = (r_state == S_LOAD) & ~i_set_coeffs;
    assign w_flush_done = (r_state == S_FLUSH) & (r_flush_cnt == LAST_IDX);
    assign w_sample     = (r_state == S_RUN) & w_accept;
    assign w_enter_load = (w_next_state == S_LOAD) & (r_state != S_LOAD);
    assign w_real_tap   = r_pipe_valid[FIR_LATENCY-1] & ~r_pipe_flush[FIR_LATENCY-1];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_set_coeffs) w_next_state = S_LOAD;
            S_LOAD:  begin
                if (w_abort)         w_next_state = S_IDLE;
                else if (w_last_tap) w_next_state = S_FLUSH;
            end
            S_FLUSH: if (w_flush_done) w_next_state = S_RUN;
            S_RUN:   if (i_set_coeffs) w_next_state = S_LOAD;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready = 1'b0;
        case (r_state)
            S_IDLE, S_LOAD: o_in_ready = 1'b1;
            S_RUN:          o_in_ready = ~i_set_coeffs;
            default:        o_in_ready = 1'b0;
        endcase
        o_busy = (r_state == S_LOAD) | (r_state == S_FLUSH);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tap_cnt      <= '0;
            r_flush_cnt    <= '0;
            r_coeff_we     <= 1'b0;
            r_coeff_addr   <= '0;
            r_coeff_data   <= '0;
            r_fir_valid    <= 1'b0;
            r_fir_flush    <= 1'b0;
            r_fir_data     <= '0;
            r_coeffs_ready <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            if (w_coeff_wr)             r_tap_cnt <= w_tap_idx + CNT_W'(1);
            else if (r_state != S_LOAD) r_tap_cnt <= '0;

            if (r_state == S_FLUSH) r_flush_cnt <= w_flush_done ? '0 : r_flush_cnt + CNT_W'(1);
            else                    r_flush_cnt <= '0;

            r_coeff_we <= w_coeff_wr;
            if (w_coeff_wr) begin
                r_coeff_addr <= w_tap_idx[ADDR_W-1:0];
                r_coeff_data <= i_in_data;
            end

            r_fir_valid <= w_sample | (r_state == S_FLUSH);
            r_fir_flush <= (r_state == S_FLUSH);
            if (r_state == S_FLUSH) r_fir_data <= '0;
            else if (w_sample)      r_fir_data <= i_in_data;

            if (w_last_tap)        r_coeffs_ready <= 1'b1;
            else if (w_enter_load) r_coeffs_ready <= 1'b0;

            // A new error event outranks a clear in the same cycle.
            if (w_drop | w_abort) r_err <= 1'b1;
            else if (i_err_clr)   r_err <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pipe_valid <= '0;
            r_pipe_flush <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_pipe_valid[0] <= r_fir_valid;
            r_pipe_flush[0] <= r_fir_flush;
            for (int i = 1; i < FIR_LATENCY; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_flush[i] <= r_pipe_flush[i-1];
            end
            r_out_valid <= w_real_tap;
            if (w_real_tap) r_out_data <= i_fir_result;
        end
    end

    assign o_coeff_we     = r_coeff_we;
    assign o_coeff_addr   = r_coeff_addr;
    assign o_coeff_data   = r_coeff_data;
    assign o_fir_valid    = r_fir_valid;
    assign o_fir_data     = r_fir_data;
    assign o_out_valid    = r_out_valid;
    assign o_out_data     = r_out_data;
    assign o_coeffs_ready = r_coeffs_ready;
    assign o_err          = r_err;

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Scoreboard bench for fir_coeff_sequencer: a small FIR stand-in drives i_fir_result, and expected
// coefficient writes, sample strobes and results are queued with the cycle they must appear in.
module tb_fir_coeff_sequencer;

    localparam int NUM_TAPS    = 4;
    localparam int DATA_W      = 8;
    localparam int OUT_W       = 11;
    localparam int FIR_LATENCY = 2;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        i_set_coeffs;
    logic                        i_in_valid;
    logic [DATA_W-1:0]           i_in_data;
    logic                        o_in_ready;
    logic                        o_coeff_we;
    logic [$clog2(NUM_TAPS)-1:0] o_coeff_addr;
    logic [DATA_W-1:0]           o_coeff_data;
    logic                        o_fir_valid;
    logic [DATA_W-1:0]           o_fir_data;
    logic [OUT_W-1:0]            i_fir_result;
    logic                        o_out_valid;
    logic [OUT_W-1:0]            o_out_data;
    logic                        o_coeffs_ready;
    logic                        o_busy;
    logic                        o_err;
    logic                        i_err_clr;

    fir_coeff_sequencer #(
        .NUM_TAPS(NUM_TAPS), .DATA_W(DATA_W), .OUT_W(OUT_W), .FIR_LATENCY(FIR_LATENCY)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_set_coeffs(i_set_coeffs), .i_in_valid(i_in_valid),
        .i_in_data(i_in_data), .o_in_ready(o_in_ready), .o_coeff_we(o_coeff_we),
        .o_coeff_addr(o_coeff_addr), .o_coeff_data(o_coeff_data), .o_fir_valid(o_fir_valid),
        .o_fir_data(o_fir_data), .i_fir_result(i_fir_result), .o_out_valid(o_out_valid),
        .o_out_data(o_out_data), .o_coeffs_ready(o_coeffs_ready), .o_busy(o_busy),
        .o_err(o_err), .i_err_clr(i_err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cycle;
        int addr;
        int data;
    } exp_t;

    exp_t expCoeff[$];
    exp_t expFir[$];
    exp_t expOut[$];
    exp_t monE;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    // FIR stand-in: coefficient RAM, delay line, and a FIR_LATENCY-deep result pipe.
    int               coeffMem[NUM_TAPS];
    int               delayLine[NUM_TAPS];
    logic [OUT_W-1:0] resPipe[FIR_LATENCY];

    function automatic logic [OUT_W-1:0] firSum(input logic [DATA_W-1:0] x0);
        int acc;
        acc = coeffMem[0] * int'(x0);
        for (int k = 1; k < NUM_TAPS; k++) acc += coeffMem[k] * delayLine[k-1];
        return OUT_W'(acc);
    endfunction

    always @(posedge clk) begin
        if (o_coeff_we) coeffMem[o_coeff_addr] <= int'(o_coeff_data);
        if (o_fir_valid) begin
            delayLine[0] <= int'(o_fir_data);
            for (int k = 1; k < NUM_TAPS; k++) delayLine[k] <= delayLine[k-1];
            resPipe[0] <= firSum(o_fir_data);
        end else begin
            resPipe[0] <= 11'h5A5;
        end
        for (int i = 1; i < FIR_LATENCY; i++) resPipe[i] <= resPipe[i-1];
    end

    assign i_fir_result = resPipe[FIR_LATENCY-1];

    // Monitor: every strobe the DUT raises must match the head of its queue, including the cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_coeff_we) begin
                if (expCoeff.size() == 0) checkOutput("coeff_we_unexpected", 1, 0);
                else begin
                    monE = expCoeff.pop_front();
                    checkOutput("coeff_cycle", cyc, monE.cycle);
                    checkOutput("coeff_addr", int'(o_coeff_addr), monE.addr);
                    checkOutput("coeff_data", int'(o_coeff_data), monE.data);
                end
            end
            if (o_fir_valid) begin
                if (expFir.size() == 0) checkOutput("fir_valid_unexpected", 1, 0);
                else begin
                    monE = expFir.pop_front();
                    checkOutput("fir_cycle", cyc, monE.cycle);
                    checkOutput("fir_data", int'(o_fir_data), monE.data);
                end
            end
            if (o_out_valid) begin
                if (expOut.size() == 0) checkOutput("out_valid_unexpected", 1, 0);
                else begin
                    monE = expOut.pop_front();
                    checkOutput("out_cycle", cyc, monE.cycle);
                    checkOutput("out_data", int'(o_out_data), monE.data);
                end
            end
        end
    end

    task automatic applyStimulus(input logic set, input logic valid, input logic [7:0] data,
                                 input logic clr);
        i_set_coeffs = set;
        i_in_valid   = valid;
        i_in_data    = data;
        i_err_clr    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input int kind, input int cycle, input int addr, input int data);
        exp_t e;
        e.cycle = cycle;
        e.addr  = addr;
        e.data  = data;
        if (kind == 0)      expCoeff.push_back(e);
        else if (kind == 1) expFir.push_back(e);
        else                expOut.push_back(e);
    endtask

    logic [7:0] samples[3]  = '{8'h10, 8'h20, 8'h30};
    int         sampleY[3]  = '{16, 64, 160};
    int         flushSteps;

    initial begin
        i_set_coeffs = 1'b0;
        i_in_valid   = 1'b0;
        i_in_data    = '0;
        i_err_clr    = 1'b0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", int'(o_in_ready), 1);
        checkOutput("rst_busy", int'(o_busy), 0);
        checkOutput("rst_err", int'(o_err), 0);
        checkOutput("rst_coeffs_ready", int'(o_coeffs_ready), 0);
        checkOutput("rst_fir_valid", int'(o_fir_valid), 0);
        checkOutput("rst_out_valid", int'(o_out_valid), 0);
        checkOutput("rst_out_data", int'(o_out_data), 0);
        checkOutput("rst_coeff_we", int'(o_coeff_we), 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

        // Full coefficient load 1..4, then a NUM_TAPS-long zero flush.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < NUM_TAPS; k++) begin
            pushExp(0, cyc + 1, k, k + 1);
            applyStimulus(1'b1, 1'b1, 8'(k + 1), 1'b0);
        end
        checkOutput("load_coeffs_ready", int'(o_coeffs_ready), 1);
        checkOutput("flush_busy", int'(o_busy), 1);
        checkOutput("flush_in_ready", int'(o_in_ready), 0);
        for (int k = 0; k < NUM_TAPS; k++) pushExp(1, cyc + 1 + k, 0, 0);
        flushSteps = 0;
        i_set_coeffs = 1'b0;
        i_in_valid   = 1'b0;
        while (!o_in_ready && flushSteps < 20) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
            flushSteps++;
        end
        checkOutput("flush_length", flushSteps, NUM_TAPS);

        // Back-to-back samples through the FIR stand-in.
        for (int s = 0; s < 3; s++) begin
            pushExp(1, cyc + 1, 0, int'(samples[s]));
            pushExp(2, cyc + 4, 0, sampleY[s]);
            applyStimulus(1'b0, 1'b1, samples[s], 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

        // Sample 0x40 then set_coeffs with 0x55 on the bus: 0x55 refused, 0x40 still emerges.
        pushExp(1, cyc + 1, 0, 8'h40);
        pushExp(2, cyc + 4, 0, 320);
        applyStimulus(1'b0, 1'b1, 8'h40, 1'b0);
        i_set_coeffs = 1'b1;
        i_in_valid   = 1'b1;
        i_in_data    = 8'h55;
        #1;
        checkOutput("run_set_in_ready", int'(o_in_ready), 0);
        @(posedge clk);
        #1;
        checkOutput("reload_busy", int'(o_busy), 1);
        checkOutput("reload_coeffs_ready", int'(o_coeffs_ready), 0);

        // Abort the load after two coefficients.
        pushExp(0, cyc + 1, 0, 5);
        applyStimulus(1'b1, 1'b1, 8'h05, 1'b0);
        pushExp(0, cyc + 1, 1, 6);
        applyStimulus(1'b1, 1'b1, 8'h06, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("abort_err", int'(o_err), 1);
        checkOutput("abort_coeffs_ready", int'(o_coeffs_ready), 0);
        checkOutput("abort_busy", int'(o_busy), 0);

        applyStimulus(1'b0, 1'b1, 8'h77, 1'b0);
        checkOutput("drop_err_kept", int'(o_err), 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("err_clr", int'(o_err), 0);
        applyStimulus(1'b0, 1'b1, 8'h99, 1'b1);
        checkOutput("err_set_beats_clr", int'(o_err), 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("err_clr_again", int'(o_err), 0);

        // Reload, then reset during the second flush cycle.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < NUM_TAPS; k++) begin
            pushExp(0, cyc + 1, k, 9 - k);
            applyStimulus(1'b1, 1'b1, 8'(9 - k), 1'b0);
        end
        pushExp(1, cyc + 1, 0, 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midflush_fir_valid", int'(o_fir_valid), 0);
        checkOutput("midflush_coeffs_ready", int'(o_coeffs_ready), 0);
        checkOutput("midflush_busy", int'(o_busy), 0);
        checkOutput("midflush_in_ready", int'(o_in_ready), 1);
        checkOutput("midflush_out_data", int'(o_out_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("post_reset_busy", int'(o_busy), 0);

        checkOutput("coeff_queue_left", expCoeff.size(), 0);
        checkOutput("fir_queue_left", expFir.size(), 0);
        checkOutput("out_queue_left", expOut.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        checkOutput("global_timeout", 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
